// File: rtl/kamus_lsu_if.sv
// kamus_lsu_if: req/gnt/rvalid data-memory bus between the LSU and data memory.
//   master (LSU side): drives data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o;
//                      receives data_gnt_i, data_rvalid_i, data_rdata_i.
//   slave  (memory side): the mirror image.
interface kamus_lsu_if;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/kamus_lsu.sv
// kamus_lsu: MEM-stage load/store unit.
//   Accepts one record per cycle from execute (valid_i/ready_o). Memory ops
//   (LW/LH/LHU/LB/LBU/SW/SH/SB) run one req/gnt/rvalid transaction on the bus
//   interface; every other op passes through to writeback one cycle later.
//   Ports: clk_i, rst_ni (async active-low); upstream valid_i, ready_o,
//   operation_i, ex_i, store_data_i, rd_i; data bus via kamus_lsu_if.master;
//   writeback wb_valid_o, wb_we_o, wb_rd_o, wb_data_o; exception exc_o,
//   exc_cause_o, exc_addr_o.
//   Optional macro KAMUS_LSU_MISALIGN_TRAP_EN: misaligned word/halfword ops
//   raise an exception instead of being silently aligned.
module kamus_lsu (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [5:0]        operation_i,
  input  logic [31:0]       ex_i,
  input  logic [31:0]       store_data_i,
  input  logic [4:0]        rd_i,
  kamus_lsu_if.master       bus,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              exc_o,
  output logic [3:0]        exc_cause_o,
  output logic [31:0]       exc_addr_o
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned XLEN = 32;

  localparam logic [OP_W-1:0] OP_LW  = 6'd1;
  localparam logic [OP_W-1:0] OP_LH  = 6'd2;
  localparam logic [OP_W-1:0] OP_LHU = 6'd3;
  localparam logic [OP_W-1:0] OP_LB  = 6'd4;
  localparam logic [OP_W-1:0] OP_LBU = 6'd5;
  localparam logic [OP_W-1:0] OP_SW  = 6'd6;
  localparam logic [OP_W-1:0] OP_SH  = 6'd7;
  localparam logic [OP_W-1:0] OP_SB  = 6'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched transaction
  logic [XLEN-1:0] r_addr;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_wdata;
  logic            r_store;
  logic [OP_W-1:0] r_op;
  logic [4:0]      r_rd;

  // Writeback record
  logic            r_wb_valid;
  logic            r_wb_we;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  // Decode of the incoming record
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_mem;
  logic            w_is_word;
  logic            w_is_half;
  logic [XLEN-1:0] w_addr;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic            w_accept;
  logic            w_trap;
  logic            w_start;
  logic            w_resp_done;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_load_data;

  // Operation class decode
  always_comb begin
    w_is_load  = (operation_i == OP_LW) || (operation_i == OP_LH) ||
                 (operation_i == OP_LHU) || (operation_i == OP_LB) ||
                 (operation_i == OP_LBU);
    w_is_store = (operation_i == OP_SW) || (operation_i == OP_SH) ||
                 (operation_i == OP_SB);
    w_is_mem   = w_is_load || w_is_store;
    w_is_word  = (operation_i == OP_LW) || (operation_i == OP_SW);
    w_is_half  = (operation_i == OP_LH) || (operation_i == OP_LHU) ||
                 (operation_i == OP_SH);
  end

  // Natural alignment by size; misaligned low bits are dropped
  always_comb begin
    w_addr  = ex_i;
    w_be    = 4'(4'b0001 << ex_i[1:0]);
    w_wdata = {4{store_data_i[7:0]}};
    if (w_is_word) begin
      w_addr  = {ex_i[31:2], 2'b00};
      w_be    = 4'b1111;
      w_wdata = store_data_i;
    end else if (w_is_half) begin
      w_addr  = {ex_i[31:1], 1'b0};
      w_be    = ex_i[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{store_data_i[15:0]}};
    end
  end

  assign w_accept = valid_i && (r_state == S_IDLE);

`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (w_is_word && (ex_i[1:0] != 2'b00)) ||
                      (w_is_half && ex_i[0]);
  assign w_trap     = w_accept && w_is_mem && w_misalign;
`else
  assign w_trap     = 1'b0;
`endif

  assign w_start     = w_accept && w_is_mem && !w_trap;
  assign w_resp_done = (r_state == S_RESP) && bus.data_rvalid_i;

  // State register; async reset drops the request immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)            w_state_nxt = S_REQ;
      S_REQ:   if (bus.data_gnt_i)     w_state_nxt = S_RESP;
      S_RESP:  if (bus.data_rvalid_i)  w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready_o        = 1'b0;
    bus.data_req_o = 1'b0;
    case (r_state)
      S_IDLE:  ready_o        = 1'b1;
      S_REQ:   bus.data_req_o = 1'b1;
      default: ;
    endcase
  end

  // Transaction latch; bus fields stay stable through REQ
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_store <= 1'b0;
      r_op    <= '0;
      r_rd    <= '0;
    end else if (w_start) begin
      r_addr  <= w_addr;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_store <= w_is_store;
      r_op    <= operation_i;
      r_rd    <= rd_i;
    end
  end

  assign bus.data_addr_o  = {r_addr[31:2], 2'b00};
  assign bus.data_we_o    = r_store;
  assign bus.data_be_o    = r_be;
  assign bus.data_wdata_o = r_wdata;

  // Load formatting: shift the addressed lane down, then extend
  assign w_lane = bus.data_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_data = bus.data_rdata_i;
    case (r_op)
      OP_LB:   w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      OP_LBU:  w_load_data = {24'd0, w_lane[7:0]};
      OP_LH:   w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      OP_LHU:  w_load_data = {16'd0, w_lane[15:0]};
      default: w_load_data = bus.data_rdata_i;
    endcase
  end

  // Writeback record: pass-through from IDLE or completion from RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept && !w_is_mem) begin
        r_wb_valid <= 1'b1;
        r_wb_we    <= 1'b1;
        r_wb_rd    <= rd_i;
        r_wb_data  <= ex_i;
      end else if (w_resp_done) begin
        r_wb_valid <= 1'b1;
        r_wb_we    <= !r_store;
        r_wb_rd    <= r_rd;
        r_wb_data  <= r_store ? '0 : w_load_data;
      end
    end
  end

  assign wb_valid_o = r_wb_valid;
  assign wb_we_o    = r_wb_we;
  assign wb_rd_o    = r_wb_rd;
  assign wb_data_o  = r_wb_data;

`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
  logic            r_exc;
  logic [3:0]      r_exc_cause;
  logic [XLEN-1:0] r_exc_addr;

  // One-cycle misalignment pulse; cause 4 = load, 6 = store
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exc       <= 1'b0;
      r_exc_cause <= '0;
      r_exc_addr  <= '0;
    end else begin
      r_exc <= w_trap;
      if (w_trap) begin
        r_exc_cause <= w_is_load ? 4'd4 : 4'd6;
        r_exc_addr  <= ex_i;
      end
    end
  end

  assign exc_o       = r_exc;
  assign exc_cause_o = r_exc_cause;
  assign exc_addr_o  = r_exc_addr;
`else
  assign exc_o       = 1'b0;
  assign exc_cause_o = 4'd0;
  assign exc_addr_o  = 32'd0;
`endif

endmodule

// File: tb/tb_kamus_lsu.sv
module tb_kamus_lsu;

  localparam logic [5:0] OP_ADD = 6'd20;
  localparam logic [5:0] OP_LW  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LHU = 6'd3;
  localparam logic [5:0] OP_LB  = 6'd4;
  localparam logic [5:0] OP_LBU = 6'd5;
  localparam logic [5:0] OP_SW  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SB  = 6'd8;

  localparam int NCYC = 1024;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [5:0]  operation_i;
  logic [31:0] ex_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        exc_o;
  logic [3:0]  exc_cause_o;
  logic [31:0] exc_addr_o;

  kamus_lsu_if u_bus ();

  kamus_lsu u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .operation_i  (operation_i),
    .ex_i         (ex_i),
    .store_data_i (store_data_i),
    .rd_i         (rd_i),
    .bus          (u_bus),
    .wb_valid_o   (wb_valid_o),
    .wb_we_o      (wb_we_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .exc_o        (exc_o),
    .exc_cause_o  (exc_cause_o),
    .exc_addr_o   (exc_addr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle expectation schedule; default is idle (ready, no pulses)
  bit          e_busy [NCYC];
  bit          e_req  [NCYC];
  logic [31:0] e_addr [NCYC];
  logic [3:0]  e_be   [NCYC];
  bit          e_we   [NCYC];
  logic [31:0] e_wd   [NCYC];
  bit          e_wbv  [NCYC];
  bit          e_wbwe [NCYC];
  logic [4:0]  e_wbrd [NCYC];
  logic [31:0] e_wbd  [NCYC];
  bit          e_exc  [NCYC];
  logic [3:0]  e_cause[NCYC];
  logic [31:0] e_eaddr[NCYC];
  bit          l_wb   [NCYC];
  logic [31:0] l_wbd  [NCYC];
  bit          l_bus  [NCYC];
  logic [3:0]  l_be   [NCYC];
  logic [31:0] l_wd   [NCYC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Single compare process
  always @(negedge clk) begin
    if (cyc < NCYC) begin
      chk("ready", 32'(ready_o), 32'(!e_busy[cyc]));
      chk("req", 32'(u_bus.data_req_o), 32'(e_req[cyc]));
      if (e_req[cyc]) begin
        chk("addr", u_bus.data_addr_o, e_addr[cyc]);
        chk("be", 32'(u_bus.data_be_o), 32'(e_be[cyc]));
        chk("we", 32'(u_bus.data_we_o), 32'(e_we[cyc]));
        if (e_we[cyc]) chk("wdata", u_bus.data_wdata_o, e_wd[cyc]);
      end
      chk("wb_valid", 32'(wb_valid_o), 32'(e_wbv[cyc]));
      if (e_wbv[cyc]) begin
        chk("wb_we", 32'(wb_we_o), 32'(e_wbwe[cyc]));
        chk("wb_rd", 32'(wb_rd_o), 32'(e_wbrd[cyc]));
        chk("wb_data", wb_data_o, e_wbd[cyc]);
      end
      chk("exc", 32'(exc_o), 32'(e_exc[cyc]));
      if (e_exc[cyc]) begin
        chk("exc_cause", 32'(exc_cause_o), 32'(e_cause[cyc]));
        chk("exc_addr", exc_addr_o, e_eaddr[cyc]);
      end
      if (l_wb[cyc]) chk("lit_wb_data", wb_data_o, l_wbd[cyc]);
      if (l_bus[cyc]) begin
        chk("lit_be", 32'(u_bus.data_be_o), 32'(l_be[cyc]));
        if (u_bus.data_we_o) chk("lit_wdata", u_bus.data_wdata_o, l_wd[cyc]);
      end
    end
  end

  // ---- Behavioural model ----
  function automatic int op_size(input logic [5:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic bit op_is_load(input logic [5:0] op);
    return op == OP_LW || op == OP_LH || op == OP_LHU || op == OP_LB || op == OP_LBU;
  endfunction

  function automatic bit op_is_signed(input logic [5:0] op);
    return op == OP_LH || op == OP_LB;
  endfunction

  function automatic bit traps_on();
`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] eff_addr(input logic [5:0] op, input logic [31:0] a);
    return a - (a % 32'(op_size(op)));
  endfunction

  function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] ea);
    int m;
    m = (1 << op_size(op)) - 1;
    return 4'(m << (ea % 4));
  endfunction

  function automatic logic [31:0] model_wd(input logic [5:0] op, input logic [31:0] sd);
    if (op_size(op) == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (op_size(op) == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] model_ld(input logic [5:0] op, input logic [31:0] ea,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    logic [31:0] mask;
    int          sz;
    sz   = op_size(op);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rdata >> (8 * (ea % 4))) & mask;
    if (op_is_signed(op) && (v > (mask >> 1))) v = v | ~mask;
    return v;
  endfunction

  // ---- Stimulus ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b0;
      u_bus.data_gnt_i    = stray;
      u_bus.data_rvalid_i = stray;
      u_bus.data_rdata_i  = 32'hA5A5_A5A5;
      tick();
    end
    u_bus.data_gnt_i    = 1'b0;
    u_bus.data_rvalid_i = 1'b0;
  endtask

  task automatic pass(input logic [31:0] ex, input logic [4:0] rd);
    int k;
    k = cyc;
    valid_i = 1'b1; operation_i = OP_ADD; ex_i = ex; rd_i = rd; store_data_i = ~ex;
    e_wbv[k+1] = 1'b1; e_wbwe[k+1] = 1'b1; e_wbrd[k+1] = rd; e_wbd[k+1] = ex;
    tick();
  endtask

  task automatic mem_op(input logic [5:0] op, input logic [31:0] ex, input logic [31:0] sd,
                        input logic [4:0] rd, input int stall, input int rlat,
                        input logic [31:0] rdata,
                        input bit lw_en, input logic [31:0] lw_val,
                        input bit lb_en, input logic [3:0] lb_be, input logic [31:0] lb_wd,
                        input bit hold, input logic [5:0] nop, input logic [31:0] nex,
                        input logic [4:0] nrd);
    int k, g, r;
    logic [31:0] ea;
    bit ld;
    k  = cyc;
    ld = op_is_load(op);
    valid_i = 1'b1; operation_i = op; ex_i = ex; store_data_i = sd; rd_i = rd;
    u_bus.data_gnt_i = 1'b0; u_bus.data_rvalid_i = 1'b0;
    if (traps_on() && (ex % 32'(op_size(op))) != 0) begin
      e_exc[k+1] = 1'b1; e_cause[k+1] = ld ? 4'd4 : 4'd6; e_eaddr[k+1] = ex;
      tick();
      valid_i = 1'b0;
      return;
    end
    ea = eff_addr(op, ex);
    g  = k + 1 + stall;
    r  = g + rlat;
    for (int c = k + 1; c <= g; c++) begin
      e_req[c] = 1'b1; e_addr[c] = ea & 32'hFFFF_FFFC; e_be[c] = model_be(op, ea);
      e_we[c] = !ld; e_wd[c] = model_wd(op, sd);
      l_bus[c] = lb_en; l_be[c] = lb_be; l_wd[c] = lb_wd;
    end
    for (int c = k + 1; c <= r; c++) e_busy[c] = 1'b1;
    e_wbv[r+1] = 1'b1; e_wbwe[r+1] = ld; e_wbrd[r+1] = rd;
    e_wbd[r+1] = ld ? model_ld(op, ea, rdata) : 32'd0;
    l_wb[r+1]  = lw_en; l_wbd[r+1] = lw_val;
    tick();
    if (hold) begin
      valid_i = 1'b1; operation_i = nop; ex_i = nex; rd_i = nrd;
    end else begin
      valid_i = 1'b0;
    end
    while (cyc <= r) begin
      u_bus.data_gnt_i    = (cyc == g);
      u_bus.data_rvalid_i = (cyc == r);
      u_bus.data_rdata_i  = (cyc == r) ? rdata : 32'h5A5A_5A5A;
      tick();
    end
    u_bus.data_gnt_i = 1'b0; u_bus.data_rvalid_i = 1'b0;
  endtask

  task automatic simple(input logic [5:0] op, input logic [31:0] ex, input logic [31:0] sd,
                        input logic [4:0] rd, input int stall, input int rlat,
                        input logic [31:0] rdata);
    mem_op(op, ex, sd, rd, stall, rlat, rdata, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0,
           1'b0, OP_ADD, 32'd0, 5'd0);
    valid_i = 1'b0;
  endtask

  task automatic reset_mid();
    int k;
    k = cyc;
    valid_i = 1'b1; operation_i = OP_LW; ex_i = 32'h8000; rd_i = 5'd7;
    e_busy[k+1] = 1'b1; e_req[k+1] = 1'b1; e_addr[k+1] = 32'h8000;
    e_be[k+1] = 4'hF; e_we[k+1] = 1'b0;
    tick();
    valid_i = 1'b0;
    u_bus.data_gnt_i = 1'b1;
    tick();
    u_bus.data_gnt_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    u_bus.data_rvalid_i = 1'b1; u_bus.data_rdata_i = 32'h1234_5678;
    tick();
    u_bus.data_rvalid_i = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; operation_i = OP_ADD; ex_i = '0;
    store_data_i = '0; rd_i = '0;
    u_bus.data_gnt_i = 1'b0; u_bus.data_rvalid_i = 1'b0; u_bus.data_rdata_i = '0;
    tick(); tick(); tick();
    rst_ni = 1'b1;
    idle(2, 1'b0);

    pass(32'h11, 5'd1); pass(32'h22, 5'd2); pass(32'h33, 5'd3);
    idle(2, 1'b1);

    mem_op(OP_LB, 32'h1003, 32'd0, 5'd4, 0, 1, 32'h80FF_FF7F, 1'b1, 32'hFFFF_FF80,
           1'b1, 4'b1000, 32'd0, 1'b0, OP_ADD, 32'd0, 5'd0);
    idle(1, 1'b0);
    mem_op(OP_LBU, 32'h1003, 32'd0, 5'd4, 0, 1, 32'h80FF_FF7F, 1'b1, 32'h0000_0080,
           1'b1, 4'b1000, 32'd0, 1'b0, OP_ADD, 32'd0, 5'd0);
    idle(1, 1'b0);
    mem_op(OP_SH, 32'h2002, 32'hDEAD_BEEF, 5'd5, 3, 2, 32'hFFFF_FFFF, 1'b1, 32'd0,
           1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, OP_ADD, 32'd0, 5'd0);
    idle(1, 1'b0);
    mem_op(OP_SB, 32'h1001, 32'h1234_5678, 5'd6, 1, 1, 32'd0, 1'b0, 32'd0,
           1'b1, 4'b0010, 32'h7878_7878, 1'b0, OP_ADD, 32'd0, 5'd0);
    simple(OP_LH,  32'h4002, 32'd0, 5'd8, 0, 2, 32'h8001_7FFF);
    simple(OP_LHU, 32'h4002, 32'd0, 5'd9, 2, 1, 32'h8001_7FFF);
    simple(OP_LH,  32'h4000, 32'd0, 5'd10, 0, 1, 32'h8001_7FFF);
    simple(OP_LW,  32'h5000, 32'd0, 5'd0, 1, 3, 32'hCAFE_F00D);
    simple(OP_SW,  32'h6004, 32'hA1B2_C3D4, 5'd11, 0, 1, 32'd0);
    simple(OP_LB,  32'h1001, 32'd0, 5'd12, 0, 1, 32'h0000_7F00);
    pass(32'h44, 5'd13);

    // Second LW waits in front of the busy LSU
    mem_op(OP_LW, 32'h7000, 32'd0, 5'd14, 1, 2, 32'h0BAD_F00D, 1'b0, 32'd0,
           1'b0, 4'd0, 32'd0, 1'b1, OP_LW, 32'h7004, 5'd15);
    simple(OP_LW, 32'h7004, 32'd0, 5'd15, 0, 1, 32'h600D_CAFE);
    idle(1, 1'b0);

    reset_mid();
    idle(2, 1'b1);

    mem_op(OP_LW, 32'h3001, 32'd0, 5'd16, 0, 1, 32'h1122_3344, 1'b0, 32'd0,
           1'b1, 4'hF, 32'd0, 1'b0, OP_ADD, 32'd0, 5'd0);
    idle(1, 1'b0);
    simple(OP_SH, 32'h2001, 32'h0000_CAFE, 5'd17, 1, 1, 32'd0);
    idle(1, 1'b0);
    simple(OP_LH, 32'h2003, 32'd0, 5'd18, 0, 1, 32'hFEDC_BA98);
    idle(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
